memsum_dp: RTL and testbench
============================

// Module: memsum_dp
//
// PURPOSE
// Datapath for the memory-based dedicated sum unit (computes 0+1+...+LIMIT).
// Executes the per-cycle register-file and select commands issued by the sum
// controller, and returns the loop-compare flag oAlt to that controller.
// Holds a 4-entry register file (R0 hardwired to zero), one adder, a write-source
// mux, a loop comparator, and a registered output buffer with a valid pulse.
//
// PARAMETERS
// DATA_W     8   width of register-file entries, adder, and output buffer
// LIMIT      10  loop bound; oAlt = (read-port-1 value <= LIMIT)
// INIT_CONST 1   constant written when iRSrcSel=0
//
// PORTS
// iClk        in   1       clock; all state updates on rising edge
// iRst        in   1       asynchronous, active-high reset
// iWrEn       in   1       register-file write enable
// iWrAddr     in   2       write address (0 = discard)
// iRdAddr0    in   2       read port 0 address (adder A, output buffer source)
// iRdAddr1    in   2       read port 1 address (adder B, comparator input)
// iRSrcSel    in   1       write data select: 0 = INIT_CONST, 1 = adder sum
// iOutBufSel  in   1       load output buffer from read port 0
// oAlt        out  1       rd1 <= LIMIT (unsigned), combinational
// oOutData    out  DATA_W  output buffer register
// oOutValid   out  1       one-cycle-delayed copy of iOutBufSel (registered)
// oOvf        out  1       sticky adder carry-out flag
//
// BEHAVIOUR
// - Reset (async, iRst=1): R1..R3, oOutData, oOutValid and oOvf all clear to 0
//   immediately. Asserting iRst mid-sequence discards all partial results.
// - Reads: rd0 = R[iRdAddr0] and rd1 = R[iRdAddr1], both combinational.
//   Address 0 always reads 0.
// - Adder: {carry, sum} = rd0 + rd1, computed at DATA_W+1 bits. sum is truncated
//   to DATA_W.
// - Write: on a rising edge with iWrEn=1 and iWrAddr!=0, the target register
//   loads wdata, where wdata = iRSrcSel ? sum : INIT_CONST (truncated to DATA_W).
//   Writes with iWrAddr=0 are discarded without error.
// - Read during write, same address: the read returns the pre-edge (old) value.
//   The new value is visible in the cycle after the edge.
// - oOvf: set on an edge where iWrEn=1, iWrAddr!=0, iRSrcSel=1 and carry=1.
//   It stays set until reset. It is never set by INIT_CONST writes.
// - Output buffer: on an edge with iOutBufSel=1, oOutData <= rd0.
//   oOutValid <= iOutBufSel on every edge, so each cycle of iOutBufSel=1
//   produces a 1-cycle valid one cycle later.
// - Latency: register write to read visibility is 1 cycle.
//   iOutBufSel to oOutData/oOutValid is 1 cycle.
//   oAlt has 0 cycles of latency from the read address.
// - Simultaneous write and iOutBufSel reading the same register: the buffer
//   captures the old value.
// - No internal FSM. Sequencing is owned by the controller. This block holds
//   state only in R1..R3, the output buffer, oOutValid and oOvf.
// - Nominal controller program, with each step taking one cycle:
//   1. R1 = 1.
//   2. R2 = 0+0.
//   3. R3 = 0+0.
//   4. Loop: test oAlt on R2. If set, R3 = R3+R2, then R2 = R1+R2.
//   5. Load buffer from R3.
//
// TESTING
// 1. Nominal program with defaults -> oOutData = 55 (0x37), oOutValid high for
//    exactly one cycle, oOvf = 0.
// 2. Compare boundary: R2 = 10 -> oAlt = 1; after R2 = R1 + R2 (R2 = 11) ->
//    oAlt = 0 in the next cycle.
// 3. Write INIT_CONST to address 0, then read both ports at address 0 -> both
//    read 0; R1..R3 unchanged.
// 4. DATA_W = 4: R1 = 1, then R3 = R3 + R1 repeated 16 times -> R3 wraps to 0 and
//    oOvf rises on the 16th write and stays 1.
// 5. Same edge: write R3 = R3 + R2 while iOutBufSel = 1 reads R3 -> oOutData holds
//    the old R3; rd0 shows the new R3 next cycle.
// 6. Assert iRst for 1 cycle mid-loop (R2 = 5) -> all registers and outputs are 0
//    immediately; rerunning the program yields 55.

Source files
------------

// File: rtl/memsum_dp_if.sv
// Command/status bundle between the sum controller (master) and the memsum datapath (slave).
interface memsum_dp_if #(
  parameter int DATA_W = 8
);
  logic              i_wr_en;
  logic [1:0]        i_wr_addr;
  logic [1:0]        i_rd_addr0;
  logic [1:0]        i_rd_addr1;
  logic              i_rsrc_sel;
  logic              i_outbuf_sel;
  logic              o_alt;
  logic [DATA_W-1:0] o_out_data;
  logic              o_out_valid;
  logic              o_ovf;

  modport master (
    output i_wr_en, i_wr_addr, i_rd_addr0, i_rd_addr1, i_rsrc_sel, i_outbuf_sel,
    input  o_alt, o_out_data, o_out_valid, o_ovf
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_rd_addr0, i_rd_addr1, i_rsrc_sel, i_outbuf_sel,
    output o_alt, o_out_data, o_out_valid, o_ovf
  );
endinterface

// File: rtl/memsum_dp.sv
// Datapath of the dedicated sum unit: 4-entry register file (R0 = 0), adder,
// loop comparator and registered output buffer, all driven by the sum controller.
module memsum_dp #(
  parameter int DATA_W     = 8,
  parameter int LIMIT      = 10,
  parameter int INIT_CONST = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  memsum_dp_if.slave   bus
);
  localparam logic [DATA_W-1:0] INIT_W  = DATA_W'(INIT_CONST);
  localparam logic [DATA_W:0]   LIMIT_W = (DATA_W+1)'(LIMIT);

  logic [DATA_W-1:0] r_r1, r_r2, r_r3;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_ovf;

  logic [DATA_W-1:0] w_rd0, w_rd1, w_wdata;
  logic [DATA_W:0]   w_add;
  logic              w_wr_ok;

  always_comb begin
    w_rd0 = '0;
    case (bus.i_rd_addr0)
      2'd1:    w_rd0 = r_r1;
      2'd2:    w_rd0 = r_r2;
      2'd3:    w_rd0 = r_r3;
      default: w_rd0 = '0;
    endcase
  end

  always_comb begin
    w_rd1 = '0;
    case (bus.i_rd_addr1)
      2'd1:    w_rd1 = r_r1;
      2'd2:    w_rd1 = r_r2;
      2'd3:    w_rd1 = r_r3;
      default: w_rd1 = '0;
    endcase
  end

  // Extra bit on the adder carries the overflow out for the sticky flag.
  assign w_add   = {1'b0, w_rd0} + {1'b0, w_rd1};
  assign w_wdata = bus.i_rsrc_sel ? w_add[DATA_W-1:0] : INIT_W;
  assign w_wr_ok = bus.i_wr_en && (bus.i_wr_addr != 2'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_r1        <= '0;
      r_r2        <= '0;
      r_r3        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        case (bus.i_wr_addr)
          2'd1:    r_r1 <= w_wdata;
          2'd2:    r_r2 <= w_wdata;
          2'd3:    r_r3 <= w_wdata;
          default: ;
        endcase
      end
      if (w_wr_ok && bus.i_rsrc_sel && w_add[DATA_W])
        r_ovf <= 1'b1;
      if (bus.i_outbuf_sel)
        r_out_data <= w_rd0;
      r_out_valid <= bus.i_outbuf_sel;
    end
  end

  assign bus.o_alt       = ({1'b0, w_rd1} <= LIMIT_W);
  assign bus.o_out_data  = r_out_data;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_ovf       = r_ovf;
endmodule

// File: tb/tb_memsum_dp.sv
// Directed bench for memsum_dp: nominal sum program, compare boundary, R0 writes,
// read-during-write, 4-bit wrap/overflow and mid-loop reset.
module tb_memsum_dp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  memsum_dp_if #(.DATA_W(8)) bus8 ();
  memsum_dp_if #(.DATA_W(4)) bus4 ();

  memsum_dp #(.DATA_W(8), .LIMIT(10), .INIT_CONST(1)) u_dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus8.slave)
  );

  memsum_dp #(.DATA_W(4), .LIMIT(10), .INIT_CONST(1)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given command on the 8-bit datapath; command returns to idle after.
  task automatic cyc8(input logic we, input logic [1:0] wa, input logic [1:0] ra0,
                      input logic [1:0] ra1, input logic rs, input logic ob);
    bus8.i_wr_en = we; bus8.i_wr_addr = wa; bus8.i_rd_addr0 = ra0;
    bus8.i_rd_addr1 = ra1; bus8.i_rsrc_sel = rs; bus8.i_outbuf_sel = ob;
    @(posedge clk); #1;
    bus8.i_wr_en = 1'b0; bus8.i_outbuf_sel = 1'b0;
  endtask

  task automatic cyc4(input logic we, input logic [1:0] wa, input logic [1:0] ra0,
                      input logic [1:0] ra1, input logic rs, input logic ob);
    bus4.i_wr_en = we; bus4.i_wr_addr = wa; bus4.i_rd_addr0 = ra0;
    bus4.i_rd_addr1 = ra1; bus4.i_rsrc_sel = rs; bus4.i_outbuf_sel = ob;
    @(posedge clk); #1;
    bus4.i_wr_en = 1'b0; bus4.i_outbuf_sel = 1'b0;
  endtask

  task automatic read8(input logic [1:0] a, output logic [7:0] v);
    cyc8(1'b0, 2'd0, a, 2'd0, 1'b0, 1'b1);
    v = bus8.o_out_data;
  endtask

  task automatic read4(input logic [1:0] a, output logic [3:0] v);
    cyc4(1'b0, 2'd0, a, 2'd0, 1'b0, 1'b1);
    v = bus4.o_out_data;
  endtask

  // Nominal controller program; stops early (no buffer load) when R2 reaches stop_at.
  task automatic run_program(input int stop_at, output logic stopped);
    int m_r2 = 0;
    stopped = 1'b0;
    cyc8(1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    cyc8(1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0);
    cyc8(1'b1, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (m_r2 == stop_at) begin
        stopped = 1'b1;
        break;
      end
      bus8.i_rd_addr1 = 2'd2;
      #1;
      chk($sformatf("alt_r2_%0d", m_r2), bus8.o_alt, (m_r2 <= 10));
      if (!bus8.o_alt) break;
      if (k == 39) chk("loop_bound", 1'b0, 1'b1);
      cyc8(1'b1, 2'd3, 2'd3, 2'd2, 1'b1, 1'b0);
      cyc8(1'b1, 2'd2, 2'd1, 2'd2, 1'b1, 1'b0);
      m_r2++;
    end
    if (!stopped) begin
      chk("loop_exit_r2", m_r2, 11);
      cyc8(1'b0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b1);
      chk("sum_data", bus8.o_out_data, 8'd55);
      chk("sum_valid", bus8.o_out_valid, 1'b1);
      cyc8(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      chk("sum_valid_drop", bus8.o_out_valid, 1'b0);
      chk("sum_ovf", bus8.o_ovf, 1'b0);
    end
  endtask

  initial begin
    logic       stopped;
    logic [7:0] v8;
    logic [3:0] v4;

    bus8.i_wr_en = 1'b0; bus8.i_wr_addr = 2'd0; bus8.i_rd_addr0 = 2'd0;
    bus8.i_rd_addr1 = 2'd0; bus8.i_rsrc_sel = 1'b0; bus8.i_outbuf_sel = 1'b0;
    bus4.i_wr_en = 1'b0; bus4.i_wr_addr = 2'd0; bus4.i_rd_addr0 = 2'd0;
    bus4.i_rd_addr1 = 2'd0; bus4.i_rsrc_sel = 1'b0; bus4.i_outbuf_sel = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk("rst_data", bus8.o_out_data, 8'd0);
    chk("rst_valid", bus8.o_out_valid, 1'b0);
    chk("rst_ovf", bus8.o_ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Nominal program plus compare boundary at R2=10/11
    run_program(-1, stopped);

    // Writes to R0 are discarded
    cyc8(1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    bus8.i_rd_addr1 = 2'd0;
    #1;
    chk("r0_alt", bus8.o_alt, 1'b1);
    read8(2'd0, v8); chk("r0_rd", v8, 8'd0);
    read8(2'd1, v8); chk("r1_keep", v8, 8'd1);
    read8(2'd2, v8); chk("r2_keep", v8, 8'd11);
    read8(2'd3, v8); chk("r3_keep", v8, 8'd55);

    // Same-edge write of R3 and buffer load from R3 captures the old value
    cyc8(1'b1, 2'd3, 2'd3, 2'd2, 1'b1, 1'b1);
    chk("rdw_old", bus8.o_out_data, 8'd55);
    read8(2'd3, v8); chk("rdw_new", v8, 8'd66);

    // 4-bit datapath: R3 += R1 sixteen times wraps to 0 and sets sticky overflow
    cyc4(1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    chk("w4_init_noovf", bus4.o_ovf, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cyc4(1'b1, 2'd3, 2'd3, 2'd1, 1'b1, 1'b0);
      chk($sformatf("w4_ovf_%0d", i), bus4.o_ovf, (i == 16));
    end
    read4(2'd3, v4); chk("w4_wrap", v4, 4'd0);
    cyc4(1'b1, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0);
    chk("w4_ovf_sticky", bus4.o_ovf, 1'b1);
    read4(2'd3, v4); chk("w4_after_init", v4, 4'd1);

    // Mid-loop reset at R2=5 clears everything at once, then a full rerun
    run_program(5, stopped);
    chk("stop_reached", stopped, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", bus8.o_out_data, 8'd0);
    chk("mid_rst_valid", bus8.o_out_valid, 1'b0);
    chk("mid_rst_ovf4", bus4.o_ovf, 1'b0);
    chk("mid_rst_data4", bus4.o_out_data, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    read8(2'd1, v8); chk("mid_rst_r1", v8, 8'd0);
    read8(2'd2, v8); chk("mid_rst_r2", v8, 8'd0);
    read8(2'd3, v8); chk("mid_rst_r3", v8, 8'd0);
    run_program(-1, stopped);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
